// File: rtl/fsm_seq_pkg.sv
// rtl/fsm_seq_pkg.sv - shared types, defaults and width helper for the FSM sequencer
package fsm_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RST_FSM = 3'd1,
    DRIVE   = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } seq_state_t;

  localparam int DEF_N          = 16;
  localparam int DEF_RST_CYC    = 2;
  localparam int DEF_SAMPLE_DLY = 1;

  // $clog2 that never returns zero, so a one-bit range stays a legal vector
  function automatic int clog2w(input int x);
    return (x <= 2) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/fsm_seq_ctrl_if.sv
// rtl/fsm_seq_ctrl_if.sv - control/status bus between test logic and the sequencer
interface fsm_seq_ctrl_if #(parameter int N = fsm_seq_pkg::DEF_N);

  localparam int LW = fsm_seq_pkg::clog2w(N + 1);
  localparam int FW = fsm_seq_pkg::clog2w(N);

  logic          start;
  logic          abort;
  logic [LW-1:0] len;
  logic [N-1:0]  pattern;
  logic [N-1:0]  exp_a;
  logic [N-1:0]  exp_b;
  logic          busy;
  logic          done;
  logic          pass;
  logic [LW-1:0] err_count;
  logic [FW-1:0] first_err;

  modport master (
    output start, abort, len, pattern, exp_a, exp_b,
    input  busy, done, pass, err_count, first_err
  );

  modport slave (
    input  start, abort, len, pattern, exp_a, exp_b,
    output busy, done, pass, err_count, first_err
  );

endinterface

// File: rtl/fsm_seq_shreg.sv
// rtl/fsm_seq_shreg.sv - load/shift register presenting one bit per cycle, bit0 first
module fsm_seq_shreg #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [N-1:0] din,
  output logic         q
);

  logic [N-1:0] data;

  // capture on load, otherwise move the next bit into position 0 while shifting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (load) begin
      data <= din;
    end else if (shift) begin
      data <= data >> 1;
    end
  end

  assign q = data[0];

endmodule

// File: rtl/fsm_seq_ctrl.sv
// rtl/fsm_seq_ctrl.sv - drives an FSM's serial input from a pattern and checks its a/b outputs
module fsm_seq_ctrl
  import fsm_seq_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int RST_CYC    = DEF_RST_CYC,
  parameter int SAMPLE_DLY = DEF_SAMPLE_DLY
) (
  input  logic           clk,
  input  logic           rst,
  fsm_seq_ctrl_if.slave  ctl,
  input  logic           a,
  input  logic           b,
  output logic           M,
  output logic           fsm_rst
);

  localparam int LW   = clog2w(N + 1);
  localparam int FW   = clog2w(N);
  localparam int CMAX = (RST_CYC > SAMPLE_DLY) ? RST_CYC : SAMPLE_DLY;
  localparam int CW   = clog2w(CMAX + 1);

  seq_state_t    state, state_next;
  logic [LW-1:0] len_r, k, err_count, err_next, len_clamped;
  logic [FW-1:0] first_err;
  logic [CW-1:0] cyc;
  logic          pass_r;
  logic          accept, abort_run, pat_q, ea_q, eb_q;
  logic          busy_o, done_o;
  logic          v0, cmp_v, cmp_a, cmp_b, mismatch, err_sat;
  logic [FW-1:0] cmp_idx;

  assign accept      = (state == IDLE) && ctl.start && !ctl.abort;
  assign abort_run   = (state != IDLE) && ctl.abort;
  assign len_clamped = (ctl.len > LW'(N)) ? LW'(N) : ctl.len;

  fsm_seq_shreg #(.N(N)) u_pat (.clk(clk), .rst(rst), .load(accept), .shift(state == DRIVE), .din(ctl.pattern), .q(pat_q));
  fsm_seq_shreg #(.N(N)) u_ea  (.clk(clk), .rst(rst), .load(accept), .shift(state == DRIVE), .din(ctl.exp_a),   .q(ea_q));
  fsm_seq_shreg #(.N(N)) u_eb  (.clk(clk), .rst(rst), .load(accept), .shift(state == DRIVE), .din(ctl.exp_b),   .q(eb_q));

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state: abort overrides everything, otherwise walk reset -> drive -> drain -> done
  always_comb begin
    state_next = state;
    if (abort_run) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_next = RST_FSM;
        RST_FSM: if (cyc == CW'(RST_CYC - 1)) state_next = (len_r == '0) ? DONE : DRIVE;
        DRIVE:   if (k == len_r - LW'(1)) state_next = (SAMPLE_DLY == 0) ? DONE : DRAIN;
        DRAIN:   if (cyc == CW'(SAMPLE_DLY - 1)) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Moore outputs decoded from the current state
  always_comb begin
    M       = 1'b0;
    fsm_rst = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state)
      RST_FSM: begin fsm_rst = 1'b1; busy_o = 1'b1; end
      DRIVE:   begin M = pat_q;      busy_o = 1'b1; end
      DRAIN:   busy_o = 1'b1;
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

  // length capture, per-state cycle counter and driven-bit index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_r <= '0;
      cyc   <= '0;
      k     <= '0;
    end else begin
      if (accept) len_r <= len_clamped;
      if (state_next != state || state == IDLE) cyc <= '0;
      else                                      cyc <= cyc + CW'(1);
      if (accept)              k <= '0;
      else if (state == DRIVE) k <= k + LW'(1);
    end
  end

  assign v0 = (state == DRIVE);

  generate
    if (SAMPLE_DLY == 0) begin : g_nodly
      assign cmp_v   = v0;
      assign cmp_a   = ea_q;
      assign cmp_b   = eb_q;
      assign cmp_idx = k[FW-1:0];
    end else begin : g_dly
      logic [SAMPLE_DLY-1:0] dv, da, db;
      logic [FW-1:0]         di [SAMPLE_DLY];

      // align expected bits and their index with the FSM's output latency; flushed on start
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dv <= '0;
          da <= '0;
          db <= '0;
          for (int i = 0; i < SAMPLE_DLY; i++) di[i] <= '0;
        end else if (accept) begin
          dv <= '0;
        end else begin
          dv[0] <= v0;
          da[0] <= ea_q;
          db[0] <= eb_q;
          di[0] <= k[FW-1:0];
          for (int i = 1; i < SAMPLE_DLY; i++) begin
            dv[i] <= dv[i-1];
            da[i] <= da[i-1];
            db[i] <= db[i-1];
            di[i] <= di[i-1];
          end
        end
      end

      assign cmp_v   = dv[SAMPLE_DLY-1];
      assign cmp_a   = da[SAMPLE_DLY-1];
      assign cmp_b   = db[SAMPLE_DLY-1];
      assign cmp_idx = di[SAMPLE_DLY-1];
    end
  endgenerate

  assign mismatch = cmp_v && (state == DRIVE || state == DRAIN) && !ctl.abort &&
                    ((a != cmp_a) || (b != cmp_b));
  assign err_sat  = (err_count == LW'(N));
  assign err_next = (mismatch && !err_sat) ? err_count + LW'(1) : err_count;

  // result registers: cleared on start, updated per compare, verdict latched entering DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
      first_err <= '0;
      pass_r    <= 1'b0;
    end else if (accept) begin
      err_count <= '0;
      first_err <= '0;
      pass_r    <= 1'b0;
    end else if (abort_run) begin
      pass_r    <= 1'b0;
    end else begin
      err_count <= err_next;
      if (mismatch && err_count == '0) first_err <= cmp_idx;
      if (state_next == DONE) pass_r <= (err_next == '0);
    end
  end

  assign ctl.busy      = busy_o;
  assign ctl.done      = done_o;
  assign ctl.pass      = pass_r;
  assign ctl.err_count = err_count;
  assign ctl.first_err = first_err;

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// tb/tb_fsm_seq_ctrl.sv - scoreboard bench for fsm_seq_ctrl with a behavioural FSM under test
module tb_fsm_seq_ctrl;

  localparam int N  = 16;
  localparam int R  = 2;
  localparam int D  = 1;
  localparam int LW = fsm_seq_pkg::clog2w(N + 1);
  localparam int FW = fsm_seq_pkg::clog2w(N);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_o, b_o, m, fsm_rst;
  logic [1:0] hist;

  fsm_seq_ctrl_if #(.N(N)) ctl ();

  fsm_seq_ctrl #(.N(N), .RST_CYC(R), .SAMPLE_DLY(D)) dut (
    .clk(clk), .rst(rst), .ctl(ctl), .a(a_o), .b(b_o), .M(m), .fsm_rst(fsm_rst)
  );

  always #5 clk = ~clk;

  // FSM being exercised: registered "101" detector on a, running parity on b
  always @(posedge clk) begin
    if (rst || fsm_rst) begin
      hist <= 2'b00;
      a_o  <= 1'b0;
      b_o  <= 1'b0;
    end else begin
      hist <= {hist[0], m};
      a_o  <= ({hist, m} == 3'b101);
      b_o  <= b_o ^ m;
    end
  end

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    int c0;
    int lat;
    int pass;
    int err;
    int first;
    int ones;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   m_ones = 0;
  bit   prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // reference behaviour of the FSM from its definition: a_k = bits k-2..k read 1,0,1; b_k = parity of bits 0..k
  function automatic void ref_model(input logic [N-1:0] p, output logic [N-1:0] ea, output logic [N-1:0] eb);
    logic par;
    par = 1'b0;
    for (int kk = 0; kk < N; kk++) begin
      par    = par ^ p[kk];
      eb[kk] = par;
      ea[kk] = 1'b0;
      if (kk >= 2) ea[kk] = p[kk] & ~p[kk-1] & p[kk-2];
    end
  endfunction

  function automatic exp_t make_exp(input int lenv, input logic [N-1:0] pat, input logic [N-1:0] bad);
    exp_t e;
    int lc;
    lc      = (lenv > N) ? N : lenv;
    e.c0    = 0;
    e.err   = 0;
    e.first = 0;
    e.ones  = 0;
    for (int kk = 0; kk < lc; kk++) begin
      if (bad[kk]) begin
        if (e.err == 0) e.first = kk;
        e.err++;
      end
      if (pat[kk]) e.ones++;
    end
    if (e.err > N) e.err = N;
    e.pass = (e.err == 0) ? 1 : 0;
    e.lat  = (lc == 0) ? R + 1 : R + lc + D + 1;
    return e;
  endfunction

  // monitor: pops the scoreboard on every done pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (prev_done) check("done_one_cycle", ctl.done, 0);
        if (ctl.start && !ctl.busy && !ctl.done && !ctl.abort) m_ones = 0;
        else if (m) m_ones++;
        if (ctl.done) begin
          check("busy_low_at_done", ctl.busy, 0);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc_cnt);
          end else begin
            e = sb.pop_front();
            check("latency", cyc_cnt - e.c0, e.lat);
            check("pass", ctl.pass, e.pass);
            check("err_count", ctl.err_count, e.err);
            check("first_err", ctl.first_err, e.first);
            check("m_ones", m_ones, e.ones);
          end
          done_cnt++;
        end
        prev_done = ctl.done;
      end
    end
  end

  task automatic start_run(input int lenv, input logic [N-1:0] pat, input logic [N-1:0] fa_m,
                           input logic [N-1:0] fb_m, input bit expect_done);
    logic [N-1:0] ea, eb;
    exp_t e;
    @(posedge clk);
    #2;
    ref_model(pat, ea, eb);
    ctl.len     = LW'(lenv);
    ctl.pattern = pat;
    ctl.exp_a   = ea ^ fa_m;
    ctl.exp_b   = eb ^ fb_m;
    ctl.start   = 1'b1;
    if (expect_done) begin
      e    = make_exp(lenv, pat, fa_m | fb_m);
      e.c0 = cyc_cnt;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    check("busy_after_start", ctl.busy, 1);
    #1;
    ctl.start = 1'b0;
  endtask

  task automatic wait_done(input int base);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done_cnt != base) return;
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: got no done expected one within 300 cycles");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, lenv;
    logic [N-1:0] pat, fa_m, fb_m, p5, p6;

    ctl.start   = 1'b0;
    ctl.abort   = 1'b0;
    ctl.len     = '0;
    ctl.pattern = '0;
    ctl.exp_a   = '0;
    ctl.exp_b   = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {ctl.busy, ctl.done, ctl.pass, ctl.err_count, ctl.first_err, m, fsm_rst}, 0);
    @(negedge clk);
    rst = 1'b0;

    // clean run, then the same run with one expected-a bit flipped
    base = done_cnt; start_run(4, 16'b1011, 16'h0000, 16'h0000, 1'b1); wait_done(base);
    base = done_cnt; start_run(4, 16'b1011, 16'h0004, 16'h0000, 1'b1); wait_done(base);

    // zero length: straight from FSM reset to done, M never driven
    base = done_cnt; start_run(0, 16'hA5A5, 16'h0000, 16'h0000, 1'b1); wait_done(base);

    // over-long length clamps to N; every bit wrong
    base = done_cnt; start_run(20, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1); wait_done(base);

    // abort while driving bit 3, then a normal run two cycles later
    base = done_cnt;
    p5   = 16'h00BE;
    start_run(8, p5, 16'h0001, 16'h0000, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    check("m_at_k3", m, p5[3]);
    ctl.abort = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", ctl.busy, 0);
    check("abort_pass", ctl.pass, 0);
    check("abort_err_partial", ctl.err_count, 1);
    check("abort_first_err", ctl.first_err, 0);
    check("abort_m_fsm_rst", {m, fsm_rst}, 0);
    #1;
    ctl.abort = 1'b0;
    check("abort_no_done", done_cnt, base);
    start_run(6, 16'h002D, 16'h0000, 16'h0010, 1'b1); wait_done(base);

    // start pulsed while busy must not disturb the captured run
    base = done_cnt;
    p6   = 16'h03A7;
    start_run(10, p6, 16'h0000, 16'h0000, 1'b1);
    ctl.start   = 1'b1;
    ctl.pattern = ~p6;
    ctl.exp_a   = ~ctl.exp_a;
    ctl.exp_b   = ~ctl.exp_b;
    ctl.len     = LW'(3);
    @(posedge clk);
    #2;
    ctl.start = 1'b0;
    wait_done(base);

    // reset mid-drive clears every output before the next clock edge
    base = done_cnt;
    start_run(10, p6, 16'h0001, 16'h0000, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_run", {ctl.busy, ctl.done, ctl.pass, ctl.err_count, ctl.first_err, m, fsm_rst}, 0);
    @(negedge clk);
    rst = 1'b0;
    start_run(7, 16'h0055, 16'h0000, 16'h0000, 1'b1); wait_done(base);

    // randomized runs against the reference model
    for (int i = 0; i < 40; i++) begin
      lenv = $urandom_range(0, N + 4);
      pat  = N'($urandom);
      fa_m = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom & $urandom & $urandom);
      fb_m = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom & $urandom & $urandom);
      base = done_cnt;
      start_run(lenv, pat, fa_m, fb_m, 1'b1);
      wait_done(base);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
